dmem_responder: RTL and testbench

- Data-memory responder on the far side of the CPU memory-stage load/store interface.
- Accepts one load/store request at a time from the memory stage and holds a word-organised RAM.
- Applies byte-lane writes and returns aligned, sign/zero-extended load data after a configurable number of wait states.
- Response uses a valid/ready handshake so the pipeline can stall on it.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 55 +++++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I size codes,
// FSM state encoding and wait-counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: write enables/replication and load extension.
// DMEM_MISALIGN_ERR_EN: flag misaligned H/W accesses instead of truncating them.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = rword[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        byte_en   = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        illegal   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                byte_en   = '1;
                wdata_rep = wdata;
                rdata_ext = rword;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0])
                    || ((funct3 == F3_W) && (addr_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store, word RAM, fixed wait
// states, valid/ready response. Misalign policy set by DMEM_MISALIGN_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    logic [31:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0]  idx;
    logic [31:0]        rword;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_rep;
    logic [31:0]        rdata_ext;
    logic               misalign;
    logic               illegal;
    logic               bad_req;
    logic               commit;
    logic               ram_we;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign idx   = addr_q[ADDR_W+1:2];
    assign rword = mem[idx];

    dmem_lane_align u_lane_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (misalign),
        .illegal   (illegal)
    );

    // Unsigned load encodings are meaningless as stores.
    assign bad_req = illegal | misalign | (we_q & f3_q[2]);
    // Counter is loaded with WAIT_STATES and commits one edge after reaching
    // zero, giving 1 + WAIT_STATES cycles from accept to rsp_valid.
    assign commit  = (state_q == WAIT) && (cnt_q == '0);
    assign ram_we  = commit && we_q && !bad_req && rst_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = WS_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bad_req;
                    rsp_rdata_d = (bad_req || we_q) ? '0 : rdata_ext;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (ram_we && byte_en[i]) begin
                mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned WS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] ram_m [1024];

    dmem_responder #(
        .DEPTH       (1024),
        .ADDR_W      (10),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: RV32I load/store semantics on a plain word array.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int unsigned idx;
        int unsigned b;
        int unsigned h;
        logic [31:0] w;
        logic [7:0]  by;
        logic [15:0] hw;
        idx = int'(a[11:2]);
        b   = int'(a[1:0]);
        h   = int'(a[1]);
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
`ifdef DMEM_MISALIGN_ERR_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) err = 1'b1;
`endif
        rd = '0;
        if (err) return;
        w  = ram_m[idx];
        by = 8'((w >> (8 * b)) & 32'hFF);
        hw = 16'((w >> (16 * h)) & 32'hFFFF);
        if (we) begin
            case (f3)
                3'd0: w = (w & ~(32'hFF << (8 * b))) | ({24'b0, wd[7:0]} << (8 * b));
                3'd1: w = (w & ~(32'hFFFF << (16 * h))) | ({16'b0, wd[15:0]} << (16 * h));
                default: w = wd;
            endcase
            ram_m[idx] = w;
        end else begin
            case (f3)
                3'd0: rd = 32'($signed(by));
                3'd1: rd = 32'($signed(hw));
                3'd4: rd = 32'(by);
                3'd5: rd = 32'(hw);
                default: rd = w;
            endcase
        end
    endfunction

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom();
        req_wdata  = $urandom();
        check("req_ready_busy", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_valid(output bit ok);
        int unsigned n;
        n  = 0;
        ok = 1'b0;
        while (n < 40 && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid) ok = 1'b1;
        end
        check("latency", ok ? n : 32'd0, 32'(1 + WS));
    endtask

    task automatic release_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rel_valid", 32'(rsp_valid), 32'd0);
        check("rel_rdata", rsp_rdata, 32'd0);
        check("rel_err", 32'(rsp_err), 32'd0);
        check("rel_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        bit          ok;
        int unsigned stall;
        model(we, f3, a, wd, erd, eer);
        send(we, f3, a, wd);
        wait_valid(ok);
        rd = rsp_rdata;
        er = rsp_err;
        if (ok) begin
            check("rsp_rdata", rsp_rdata, erd);
            check("rsp_err", 32'(rsp_err), 32'(eer));
            stall = $urandom_range(0, 2);
            for (int unsigned i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_rdata", rsp_rdata, erd);
            end
            release_rsp();
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] erd;
        logic        eer;
        bit          ok;

        for (int unsigned i = 0; i < 1024; i++) ram_m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", 32'(rsp_valid), 32'd0);
        check("init_rdata", rsp_rdata, 32'd0);
        check("init_err", 32'(rsp_err), 32'd0);
        check("init_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Zero the window of words the bench reads from.
        for (int unsigned i = 0; i < 16; i++) xact(1'b1, 3'd2, 32'(i * 4), 32'd0, rd, er);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
        check("t1_lw", rd, 32'hDEADBEEF);
        check("t1_err", 32'(er), 32'd0);

        xact(1'b1, 3'd0, 32'h13, 32'h00000080, rd, er);
        xact(1'b0, 3'd0, 32'h13, 32'h0, rd, er);
        check("t2_lb", rd, 32'hFFFFFF80);
        xact(1'b0, 3'd4, 32'h13, 32'h0, rd, er);
        check("t2_lbu", rd, 32'h00000080);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
        check("t2_lw", rd, 32'h80ADBEEF);

        xact(1'b1, 3'd1, 32'h22, 32'h0000F00D, rd, er);
        xact(1'b0, 3'd1, 32'h22, 32'h0, rd, er);
        check("t3_lh", rd, 32'hFFFFF00D);
        xact(1'b0, 3'd5, 32'h22, 32'h0, rd, er);
        check("t3_lhu", rd, 32'h0000F00D);
        xact(1'b0, 3'd1, 32'h20, 32'h0, rd, er);
        check("t3_lh_zero", rd, 32'h00000000);

        // Backpressure with a competing request held on the input.
        model(1'b0, 3'd2, 32'h10, 32'h0, erd, eer);
        send(1'b0, 3'd2, 32'h10, 32'h0);
        wait_valid(ok);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h14;
        req_wdata  = 32'hCAFEF00D;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, erd);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        release_rsp();
        xact(1'b0, 3'd2, 32'h14, 32'h0, rd, er);
        check("bp_not_taken", rd, 32'h00000000);

        xact(1'b1, 3'd2, 32'h10, 32'h12345678, rd, er);
        xact(1'b0, 3'd2, 32'h11, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
        check("t5_mis_err", 32'(er), 32'd1);
        check("t5_mis_rdata", rd, 32'h0);
`else
        check("t5_mis_err", 32'(er), 32'd0);
        check("t5_mis_rdata", rd, 32'h12345678);
`endif
        xact(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, rd, er);
        check("t5_ill_err", 32'(er), 32'd1);
        xact(1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, rd, er);
        check("t5_sbu_err", 32'(er), 32'd1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, rd, er);
        check("t5_unchanged", rd, 32'h12345678);

        // Reset while a store waits: must not commit.
        send(1'b1, 3'd2, 32'h30, 32'hA5A5A5A5);
        reset_pulse();
        xact(1'b0, 3'd2, 32'h30, 32'h0, rd, er);
        check("t6_abandoned", rd, 32'h00000000);

        // Reset while a store is responding: already committed.
        model(1'b1, 3'd2, 32'h34, 32'h11223344, erd, eer);
        send(1'b1, 3'd2, 32'h34, 32'h11223344);
        wait_valid(ok);
        reset_pulse();
        xact(1'b0, 3'd2, 32'h34, 32'h0, rd, er);
        check("t6_committed", rd, 32'h11223344);

        // Random traffic; upper address bits exercise wrap-around.
        for (int unsigned i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = ($urandom() & 32'hFFFF_F000) | ($urandom() & 32'h0000_003F);
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
